// File: rtl/puf_pkg.sv
// Shared types, constants and helpers for the arbiter-PUF readout controller.
package puf_pkg;

  // Capture controller states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    SAMPLE  = 3'd2,
    RESOLVE = 3'd3,
    SHOW    = 3'd4
  } puf_state_e;

  // Active-low pattern with every segment off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Number of display pages needed to show resp_w bits on 'digits' hex digits.
  function automatic int npages(input int resp_w, input int digits);
    return (resp_w + 4 * digits - 1) / (4 * digits);
  endfunction

endpackage

// File: rtl/puf_vote_acc.sv
// Per-bit vote accumulator: counts how many samples had each response bit set,
// and resolves the counts into a majority result, an instability mask and the
// mask population count.
module puf_vote_acc #(
  parameter  int RESP_W = 64,
  parameter  int VOTES  = 5,
  localparam int VW     = $clog2(VOTES + 1),
  localparam int UW     = $clog2(RESP_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              acc,
  input  logic [RESP_W-1:0] resp,
  output logic [RESP_W-1:0] result,
  output logic [RESP_W-1:0] mask,
  output logic [UW-1:0]     popcnt
);

  // Counters never exceed VOTES because exactly VOTES accumulate pulses
  // occur between clears, so no saturation logic is needed.
  logic [VW-1:0] cnt [RESP_W];

  // Clear on a new capture, add one sample per accumulate pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RESP_W; i++) cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < RESP_W; i++) cnt[i] <= '0;
    end else if (acc) begin
      for (int i = 0; i < RESP_W; i++) cnt[i] <= cnt[i] + VW'(resp[i]);
    end
  end

  // Majority vote, disagreement mask and its population count.
  always_comb begin
    result = '0;
    mask   = '0;
    popcnt = '0;
    for (int i = 0; i < RESP_W; i++) begin
      result[i] = (cnt[i] > VW'(VOTES / 2));
      mask[i]   = (cnt[i] != '0) && (cnt[i] != VW'(VOTES));
      popcnt    = popcnt + UW'(mask[i]);
    end
  end

endmodule

// File: rtl/sevensegdisp.sv
// Hex nibble to active-low seven-segment decoder (segment order gfedcba).
module sevensegdisp (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  logic [6:0] lit;

  // Active-high segment table, inverted at the output for the common-anode displays.
  always_comb begin
    lit = 7'h00;
    case (hex)
      4'h0: lit = 7'h3F;
      4'h1: lit = 7'h06;
      4'h2: lit = 7'h5B;
      4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;
      4'h5: lit = 7'h6D;
      4'h6: lit = 7'h7D;
      4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;
      4'h9: lit = 7'h6F;
      4'hA: lit = 7'h77;
      4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;
      4'hD: lit = 7'h5E;
      4'hE: lit = 7'h79;
      4'hF: lit = 7'h71;
      default: lit = 7'h00;
    endcase
    seg = ~lit;
  end

endmodule

// File: rtl/puf_readout.sv
// Capture-and-display controller for the arbiter PUF: holds a challenge, takes
// VOTES settled samples of the response, resolves them by majority and pages the
// resolved response (or the instability mask) across DIGITS hex displays.
//
// Request semantics: start and page_next are single-cycle requests with no
// ready/acknowledge. start is taken only in IDLE or SHOW (ignored otherwise,
// never queued); page_next is taken only in SHOW and loses to a same-cycle start.
module puf_readout
  import puf_pkg::*;
#(
  parameter  int CH_W   = 8,
  parameter  int RESP_W = 64,
  parameter  int DIGITS = 6,
  parameter  int VOTES  = 5,
  parameter  int SETTLE = 4,
  localparam int NPAGES = npages(RESP_W, DIGITS),
  localparam int PW     = (NPAGES > 1) ? $clog2(NPAGES) : 1,
  localparam int UW     = $clog2(RESP_W + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CH_W-1:0]        challenge_in,
  input  logic                   page_next,
  input  logic                   show_mask,
  output logic [CH_W-1:0]        puf_challenge,
  input  logic [RESP_W-1:0]      puf_response,
  output logic                   busy,
  output logic                   done,
  output logic [UW-1:0]          unstable_cnt,
  output logic [PW-1:0]          page,
  output logic [DIGITS-1:0][6:0] segment,
  output puf_state_e             fsm_state
);

  localparam int VW   = $clog2(VOTES + 1);
  localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PADW = NPAGES * DIGITS * 4;

  puf_state_e        state, state_n;
  logic              accept, acc, resolve;
  logic [SW-1:0]     settle_cnt;
  logic [VW-1:0]     samp_cnt;
  logic              settle_last;
  logic [RESP_W-1:0] result_q, mask_q;
  logic              valid;
  logic [RESP_W-1:0] acc_result, acc_mask;
  logic [UW-1:0]     acc_pop;

  assign settle_last = (settle_cnt == SW'(SETTLE - 1));
  assign busy        = (state == APPLY) || (state == SAMPLE) || (state == RESOLVE);
  assign fsm_state   = state;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    acc     = 1'b0;
    resolve = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = APPLY;
        end
      end
      APPLY: begin
        if (settle_last) state_n = SAMPLE;
      end
      SAMPLE: begin
        acc     = 1'b1;
        state_n = (samp_cnt == VW'(VOTES - 1)) ? RESOLVE : APPLY;
      end
      RESOLVE: begin
        resolve = 1'b1;
        state_n = SHOW;
      end
      SHOW: begin
        if (start) begin
          accept  = 1'b1;
          state_n = APPLY;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Settle and sample counters; the settle count restarts for every sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle_cnt <= '0;
      samp_cnt   <= '0;
    end else if (accept) begin
      settle_cnt <= '0;
      samp_cnt   <= '0;
    end else begin
      if (state == APPLY) settle_cnt <= settle_last ? '0 : settle_cnt + SW'(1);
      if (acc)            samp_cnt   <= samp_cnt + VW'(1);
    end
  end

  // Challenge is latched only when a capture is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      puf_challenge <= '0;
    else if (accept) puf_challenge <= challenge_in;
  end

  // Committed result; the previous one stays on display until RESOLVE replaces it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q     <= '0;
      mask_q       <= '0;
      unstable_cnt <= '0;
      valid        <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= resolve;
      if (resolve) begin
        result_q     <= acc_result;
        mask_q       <= acc_mask;
        unstable_cnt <= acc_pop;
        valid        <= 1'b1;
      end
    end
  end

  // Display page: cleared by every accepted start, advanced only in SHOW.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      page <= '0;
    end else if (accept) begin
      page <= '0;
    end else if ((state == SHOW) && page_next) begin
      page <= (page == PW'(NPAGES - 1)) ? '0 : page + PW'(1);
    end
  end

  puf_vote_acc #(
    .RESP_W (RESP_W),
    .VOTES  (VOTES)
  ) u_vote (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .acc    (acc),
    .resp   (puf_response),
    .result (acc_result),
    .mask   (acc_mask),
    .popcnt (acc_pop)
  );

  logic [PADW-1:0]        src_pad;
  logic [DIGITS-1:0][3:0] nib;
  logic [DIGITS-1:0]      blank;

  // Pick the nibble for each digit of the current page; the source is
  // zero-padded so a partial top nibble reads its missing bits as 0.
  always_comb begin
    src_pad = show_mask ? PADW'(mask_q) : PADW'(result_q);
    nib     = '0;
    blank   = '0;
    for (int d = 0; d < DIGITS; d++) begin
      nib[d]   = src_pad[(int'(page) * DIGITS + d) * 4 +: 4];
      blank[d] = !valid || (((int'(page) * DIGITS + d) * 4) >= RESP_W);
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [6:0] seg_raw;
    sevensegdisp u_dec (
      .hex (nib[d]),
      .seg (seg_raw)
    );
    assign segment[d] = blank[d] ? SEG_BLANK : seg_raw;
  end

endmodule

// File: tb/tb_puf_readout.sv
// Directed bench for puf_readout: a default 64-bit instance and a 24-bit,
// single-vote instance share clock and reset.
module tb_puf_readout;
  import puf_pkg::*;

  localparam logic [63:0] R   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] B63 = 64'h8000_0000_0000_0000;
  localparam logic [4:0]  BL  = 5'd16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b, page_next_a, page_next_b, show_mask;
  logic [7:0]  challenge;
  logic [63:0] resp_a;
  logic [23:0] resp_b;

  logic [7:0]      pch_a, pch_b;
  logic            busy_a, busy_b, done_a, done_b;
  logic [6:0]      ucnt_a;
  logic [4:0]      ucnt_b;
  logic [1:0]      page_a;
  logic [0:0]      page_b;
  logic [5:0][6:0] seg_a, seg_b;
  puf_state_e      st_a, st_b;

  int checks   = 0;
  int failures = 0;
  int cyc;

  logic [63:0] vec [5];
  logic [41:0] exp_q [$];

  typedef struct {
    int              npn;
    bit              sm;
    int              pg;
    logic [5:0][4:0] dg;
  } disp_t;
  disp_t tbl [6];

  puf_readout dut_a (
    .clk (clk), .reset (reset), .start (start_a), .challenge_in (challenge),
    .page_next (page_next_a), .show_mask (show_mask), .puf_challenge (pch_a),
    .puf_response (resp_a), .busy (busy_a), .done (done_a),
    .unstable_cnt (ucnt_a), .page (page_a), .segment (seg_a), .fsm_state (st_a)
  );

  puf_readout #(.CH_W(8), .RESP_W(24), .DIGITS(6), .VOTES(1), .SETTLE(1)) dut_b (
    .clk (clk), .reset (reset), .start (start_b), .challenge_in (challenge),
    .page_next (page_next_b), .show_mask (show_mask), .puf_challenge (pch_b),
    .puf_response (resp_b), .busy (busy_b), .done (done_b),
    .unstable_cnt (ucnt_b), .page (page_b), .segment (seg_b), .fsm_state (st_b)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] hex2seg(input logic [4:0] c);
    case (c)
      5'd0:  return 7'h40;
      5'd1:  return 7'h79;
      5'd2:  return 7'h24;
      5'd3:  return 7'h30;
      5'd4:  return 7'h19;
      5'd5:  return 7'h12;
      5'd6:  return 7'h02;
      5'd7:  return 7'h78;
      5'd8:  return 7'h00;
      5'd9:  return 7'h10;
      5'd10: return 7'h08;
      5'd11: return 7'h03;
      5'd12: return 7'h46;
      5'd13: return 7'h21;
      5'd14: return 7'h06;
      5'd15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  // dg[5] is the leftmost digit, dg[0] the rightmost.
  function automatic logic [41:0] mk_seg(input logic [5:0][4:0] dg);
    logic [41:0] s;
    s = '0;
    for (int d = 0; d < 6; d++) s[d*7 +: 7] = hex2seg(dg[d]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic pulse_page_a();
    page_next_a = 1'b1;
    tick();
    page_next_a = 1'b0;
  endtask

  // Start a capture on dut_a at edge 0 and run until done; vec[k] is the
  // response presented for sample k (sampled at edge 5*(k+1)).
  task automatic capture_a(input logic [7:0] ch, input bit noisy_starts, input bit with_page,
                           input bit mid_chk, input logic [41:0] mid_exp, output int c);
    int idx;
    start_a     = 1'b1;
    challenge   = ch;
    page_next_a = with_page;
    resp_a      = vec[0];
    tick();
    start_a     = 1'b0;
    page_next_a = 1'b0;
    challenge   = 8'hFF;
    chk("page_on_start", 64'(page_a), 64'd0);
    chk("busy_rise", 64'(busy_a), 64'd1);
    c = 0;
    while (c < 60) begin
      tick();
      c++;
      if (done_a) break;
      idx = c / 5;
      if (idx > 4) idx = 4;
      resp_a  = vec[idx];
      start_a = noisy_starts && (c == 2 || c == 4);
      if (mid_chk && c == 10) chk("old_result_held", 64'(seg_a), 64'(mid_exp));
    end
    start_a = 1'b0;
    chk("done_cycle", 64'(c), 64'd26);
    chk("busy_at_done", 64'(busy_a), 64'd0);
    chk("state_show", 64'(st_a), 64'(SHOW));
    chk("challenge_latched", 64'(pch_a), 64'(ch));
    tick();
    chk("done_width", 64'(done_a), 64'd0);
  endtask

  initial begin
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    page_next_a = 1'b0; page_next_b = 1'b0; show_mask = 1'b0;
    challenge = 8'h00; resp_a = '0; resp_b = '0;

    // Reset values.
    tick();
    tick();
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_pch", 64'(pch_a), 64'd0);
    chk("rst_ucnt", 64'(ucnt_a), 64'd0);
    chk("rst_page", 64'(page_a), 64'd0);
    chk("rst_state", 64'(st_a), 64'(IDLE));
    chk("rst_seg", 64'(seg_a), {22'd0, {6{7'h7F}}});
    chk("rst_seg_b", 64'(seg_b), {22'd0, {6{7'h7F}}});
    reset = 1'b1;
    tick();
    chk("idle_seg", 64'(seg_a), {22'd0, {6{7'h7F}}});

    // Stable response.
    for (int k = 0; k < 5; k++) vec[k] = R;
    capture_a(8'h5A, 1'b0, 1'b0, 1'b0, '0, cyc);
    chk("stable_ucnt", 64'(ucnt_a), 64'd0);

    tbl[0] = '{0, 1'b0, 0, {5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15}};
    tbl[1] = '{0, 1'b1, 0, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}};
    tbl[2] = '{1, 1'b0, 1, {5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9}};
    tbl[3] = '{1, 1'b0, 2, {BL, BL, 5'd0, 5'd1, 5'd2, 5'd3}};
    tbl[4] = '{0, 1'b1, 2, {BL, BL, 5'd0, 5'd0, 5'd0, 5'd0}};
    tbl[5] = '{1, 1'b0, 0, {5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15}};
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < tbl[i].npn; p++) pulse_page_a();
      show_mask = tbl[i].sm;
      #1;
      exp_q.push_back(mk_seg(tbl[i].dg));
      chk($sformatf("tbl%0d_page", i), 64'(page_a), 64'(tbl[i].pg));
      chk($sformatf("tbl%0d_seg", i), 64'(seg_a), 64'(exp_q.pop_front()));
    end
    show_mask = 1'b0;

    // Flaky bit 0: set in 2 of 5 samples.
    vec[0] = R; vec[1] = R; vec[2] = R & ~64'd1; vec[3] = R & ~64'd1; vec[4] = R & ~64'd1;
    capture_a(8'h11, 1'b0, 1'b0, 1'b0, '0, cyc);
    chk("flaky_ucnt", 64'(ucnt_a), 64'd1);
    chk("flaky_seg", 64'(seg_a), 64'(mk_seg({5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd14})));
    show_mask = 1'b1;
    #1;
    chk("flaky_mask", 64'(seg_a), 64'(mk_seg({5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1})));
    show_mask = 1'b0;

    // Majority flip: bit 0 clear in 3 of 5, bit 63 set in 3 of 5.
    vec[0] = R | B63; vec[1] = R | B63; vec[2] = (R | B63) & ~64'd1;
    vec[3] = R & ~64'd1; vec[4] = R & ~64'd1;
    capture_a(8'h22, 1'b0, 1'b0, 1'b0, '0, cyc);
    chk("flip_ucnt", 64'(ucnt_a), 64'd2);
    chk("flip_seg_p0", 64'(seg_a), 64'(mk_seg({5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd14})));
    pulse_page_a();
    pulse_page_a();
    chk("flip_page2", 64'(page_a), 64'd2);
    chk("flip_seg_p2", 64'(seg_a), 64'(mk_seg({BL, BL, 5'd8, 5'd1, 5'd2, 5'd3})));
    show_mask = 1'b1;
    #1;
    chk("flip_mask_p2", 64'(seg_a), 64'(mk_seg({BL, BL, 5'd8, 5'd0, 5'd0, 5'd0})));
    show_mask = 1'b0;

    // Restart from SHOW on page 2 with a same-cycle page_next, stray starts
    // during APPLY/SAMPLE, and the old result visible mid-capture.
    for (int k = 0; k < 5; k++) vec[k] = R;
    capture_a(8'hC3, 1'b1, 1'b1, 1'b1,
              mk_seg({5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd14}), cyc);
    chk("restart_ucnt", 64'(ucnt_a), 64'd0);
    chk("restart_seg", 64'(seg_a), 64'(mk_seg({5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15})));

    // Reset in cycle 10 of a capture.
    start_a = 1'b1;
    challenge = 8'h77;
    tick();
    start_a = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_pch", 64'(pch_a), 64'd0);
    chk("midrst_state", 64'(st_a), 64'(IDLE));
    chk("midrst_ucnt", 64'(ucnt_a), 64'd0);
    chk("midrst_seg", 64'(seg_a), {22'd0, {6{7'h7F}}});
    tick();
    reset = 1'b1;
    tick();
    capture_a(8'h3C, 1'b0, 1'b0, 1'b0, '0, cyc);
    chk("postrst_seg", 64'(seg_a), 64'(mk_seg({5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15})));

    // Small configuration: one vote, one settle cycle, single page.
    resp_b = 24'hABCDEF;
    start_b = 1'b1;
    challenge = 8'h42;
    tick();
    start_b = 1'b0;
    cyc = 0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (done_b) break;
    end
    chk("b_done_cycle", 64'(cyc), 64'd3);
    chk("b_pch", 64'(pch_b), 64'h42);
    chk("b_ucnt", 64'(ucnt_b), 64'd0);
    chk("b_seg", 64'(seg_b), 64'(mk_seg({5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15})));
    page_next_b = 1'b1;
    tick();
    page_next_b = 1'b0;
    chk("b_page_stays", 64'(page_b), 64'd0);
    chk("b_seg_after_page", 64'(seg_b), 64'(mk_seg({5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15})));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
